// File: rtl/pipe_ctrl.sv
// Pipeline control: per-stage hold fan-in, redirect arbitration (int over ex jump), flush window.
// 0-cycle redirect when the PC is free, else buffered and replayed on hold release; never issues while held.
module pipe_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int NSTAGE       = 4,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stall_req,
  input  logic              ex_jump_flag,
  input  logic [ADDR_W-1:0] ex_jump_addr,
  input  logic              int_flag,
  input  logic [ADDR_W-1:0] int_addr,
  output logic [NSTAGE-1:0] hold_flag,
  output logic [NSTAGE-2:0] flush_flag,
  output logic              pc_jump_flag,
  output logic [ADDR_W-1:0] pc_jump_addr,
  output logic              int_ack,
  output logic              redirect_pending
);

  typedef struct packed {
    logic              vld;
    logic              is_int;
    logic [ADDR_W-1:0] addr;
  } pend_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  pend_t             pend_q, pend_nxt;
  logic [3:0]        cnt_q, cnt_nxt;
  logic [NSTAGE-1:0] hold_raw;
  logic              issue_ok;
  logic              issue;
  logic              issue_int;
  logic [ADDR_W-1:0] issue_addr;
  logic              req_vld;
  logic [ADDR_W-1:0] req_addr;

  // A stall anywhere downstream freezes every stage above it.
  always_comb begin
    logic acc;
    acc = 1'b0;
    hold_raw = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      acc = acc | stall_req[i];
      hold_raw[i] = acc;
    end
  end

  assign issue_ok = rst & ~hold_raw[0];
  assign req_vld  = int_flag | ex_jump_flag;
  assign req_addr = int_flag ? int_addr : ex_jump_addr;

  always_comb begin
    issue      = 1'b0;
    issue_int  = 1'b0;
    issue_addr = '0;
    pend_nxt   = pend_q;
    if (pend_q.vld) begin
      if (issue_ok) begin
        issue        = 1'b1;
        pend_nxt.vld = 1'b0;
        // A fresh interrupt pre-empts a buffered jump; the jump is dropped.
        if (int_flag && !pend_q.is_int) begin
          issue_int  = 1'b1;
          issue_addr = int_addr;
        end else begin
          issue_int  = pend_q.is_int;
          issue_addr = pend_q.addr;
        end
      end else if (int_flag && !pend_q.is_int) begin
        pend_nxt = '{vld: 1'b1, is_int: 1'b1, addr: int_addr};
      end
    end else if (req_vld && rst) begin
      if (issue_ok) begin
        issue      = 1'b1;
        issue_int  = int_flag;
        issue_addr = req_addr;
      end else begin
        pend_nxt = '{vld: 1'b1, is_int: int_flag, addr: req_addr};
      end
    end
  end

  always_comb begin
    cnt_nxt = cnt_q;
    if (issue)
      cnt_nxt = FLUSH_LOAD;
    else if (cnt_q != 4'd0)
      cnt_nxt = cnt_q - 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
      cnt_q  <= 4'd0;
    end else begin
      pend_q <= pend_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  // Everything is forced low while reset is asserted, hold included.
  assign hold_flag        = rst ? hold_raw : '0;
  assign flush_flag       = {(NSTAGE-1){rst & (issue | (cnt_q != 4'd0) | pend_q.vld)}};
  assign pc_jump_flag     = issue;
  assign pc_jump_addr     = issue ? issue_addr : '0;
  assign int_ack          = issue & issue_int;
  assign redirect_pending = rst & pend_q.vld;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
  localparam int ADDR_W = 32;
  localparam int NSTAGE = 4;
  localparam int FLUSH_CYCLES = 2;

  logic              clk;
  logic              rst;
  logic [NSTAGE-1:0] stall_req;
  logic              ex_jump_flag;
  logic [ADDR_W-1:0] ex_jump_addr;
  logic              int_flag;
  logic [ADDR_W-1:0] int_addr;
  logic [NSTAGE-1:0] hold_flag;
  logic [NSTAGE-2:0] flush_flag;
  logic              pc_jump_flag;
  logic [ADDR_W-1:0] pc_jump_addr;
  logic              int_ack;
  logic              redirect_pending;

  pipe_ctrl #(.ADDR_W(ADDR_W), .NSTAGE(NSTAGE), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req),
    .ex_jump_flag(ex_jump_flag), .ex_jump_addr(ex_jump_addr),
    .int_flag(int_flag), .int_addr(int_addr),
    .hold_flag(hold_flag), .flush_flag(flush_flag),
    .pc_jump_flag(pc_jump_flag), .pc_jump_addr(pc_jump_addr),
    .int_ack(int_ack), .redirect_pending(redirect_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  stall;
    logic        exf;
    logic [31:0] exa;
    logic        intf;
    logic [31:0] inta;
    logic [3:0]  e_hold;
    logic [2:0]  e_flush;
    logic        e_pcj;
    logic [31:0] e_addr;
    logic        e_ack;
    logic        e_pend;
  } vec_t;

  vec_t vecs[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] st, input logic exf, input logic [31:0] exa,
                     input logic intf, input logic [31:0] inta, input logic [3:0] h,
                     input logic [2:0] fl, input logic pj, input logic [31:0] pa,
                     input logic ack, input logic pend);
    vec_t v;
    v.stall = st; v.exf = exf; v.exa = exa; v.intf = intf; v.inta = inta;
    v.e_hold = h; v.e_flush = fl; v.e_pcj = pj; v.e_addr = pa; v.e_ack = ack; v.e_pend = pend;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [3:0] st, input logic exf, input logic [31:0] exa,
                       input logic intf, input logic [31:0] inta);
    stall_req = st; ex_jump_flag = exf; ex_jump_addr = exa; int_flag = intf; int_addr = inta;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] h, input logic [2:0] fl,
                         input logic pj, input logic [31:0] pa, input logic ack, input logic pend);
    chk({tag, ".hold"}, 32'(hold_flag), 32'(h));
    chk({tag, ".flush"}, 32'(flush_flag), 32'(fl));
    chk({tag, ".pc_jump"}, 32'(pc_jump_flag), 32'(pj));
    chk({tag, ".pc_addr"}, pc_jump_addr, pa);
    chk({tag, ".int_ack"}, 32'(int_ack), 32'(ack));
    chk({tag, ".pending"}, 32'(redirect_pending), 32'(pend));
  endtask

  initial begin
    // stall ex exaddr int intaddr | hold flush pcj addr ack pend
    add(4'b0000, 0, 0, 0, 0,          4'b0000, 3'b000, 0, 0, 0, 0);
    add(4'b0100, 0, 0, 0, 0,          4'b0111, 3'b000, 0, 0, 0, 0);
    add(4'b0001, 0, 0, 0, 0,          4'b0001, 3'b000, 0, 0, 0, 0);
    add(4'b1000, 0, 0, 0, 0,          4'b1111, 3'b000, 0, 0, 0, 0);
    // immediate jump, 2-cycle flush
    add(4'b0000, 1, 32'h100, 0, 0,    4'b0000, 3'b111, 1, 32'h100, 0, 0);
    add(4'b0000, 0, 0, 0, 0,          4'b0000, 3'b111, 0, 0, 0, 0);
    add(4'b0000, 0, 0, 0, 0,          4'b0000, 3'b000, 0, 0, 0, 0);
    // buffered jump while PC held
    add(4'b0001, 1, 32'h200, 0, 0,    4'b0001, 3'b000, 0, 0, 0, 0);
    add(4'b0001, 0, 0, 0, 0,          4'b0001, 3'b111, 0, 0, 0, 1);
    add(4'b0001, 0, 0, 0, 0,          4'b0001, 3'b111, 0, 0, 0, 1);
    add(4'b0000, 0, 0, 0, 0,          4'b0000, 3'b111, 1, 32'h200, 0, 1);
    add(4'b0000, 0, 0, 0, 0,          4'b0000, 3'b111, 0, 0, 0, 0);
    add(4'b0000, 0, 0, 0, 0,          4'b0000, 3'b000, 0, 0, 0, 0);
    // same-cycle int beats ex jump
    add(4'b0000, 1, 32'h300, 1, 32'h8, 4'b0000, 3'b111, 1, 32'h8, 1, 0);
    add(4'b0000, 0, 0, 0, 0,          4'b0000, 3'b111, 0, 0, 0, 0);
    add(4'b0000, 0, 0, 0, 0,          4'b0000, 3'b000, 0, 0, 0, 0);
    // pending jump replaced by int while held; later ex ignored
    add(4'b0001, 1, 32'h300, 0, 0,    4'b0001, 3'b000, 0, 0, 0, 0);
    add(4'b0001, 0, 0, 1, 32'h8,      4'b0001, 3'b111, 0, 0, 0, 1);
    add(4'b0001, 1, 32'h400, 0, 0,    4'b0001, 3'b111, 0, 0, 0, 1);
    add(4'b0000, 0, 0, 0, 0,          4'b0000, 3'b111, 1, 32'h8, 1, 1);
    add(4'b0000, 0, 0, 0, 0,          4'b0000, 3'b111, 0, 0, 0, 0);
    add(4'b0000, 0, 0, 0, 0,          4'b0000, 3'b000, 0, 0, 0, 0);
    // int arriving on the release cycle drops the pending jump
    add(4'b0001, 1, 32'h500, 0, 0,    4'b0001, 3'b000, 0, 0, 0, 0);
    add(4'b0000, 0, 0, 1, 32'h10,     4'b0000, 3'b111, 1, 32'h10, 1, 1);
    add(4'b0000, 0, 0, 0, 0,          4'b0000, 3'b111, 0, 0, 0, 0);
    add(4'b0000, 0, 0, 0, 0,          4'b0000, 3'b000, 0, 0, 0, 0);
    // back-to-back jumps reload the flush counter
    add(4'b0000, 1, 32'h600, 0, 0,    4'b0000, 3'b111, 1, 32'h600, 0, 0);
    add(4'b0000, 1, 32'h700, 0, 0,    4'b0000, 3'b111, 1, 32'h700, 0, 0);
    add(4'b0000, 0, 0, 0, 0,          4'b0000, 3'b111, 0, 0, 0, 0);
    add(4'b0000, 0, 0, 0, 0,          4'b0000, 3'b000, 0, 0, 0, 0);
    // ex jump on the pending-issue cycle is ignored
    add(4'b0010, 1, 32'h800, 0, 0,    4'b0011, 3'b000, 0, 0, 0, 0);
    add(4'b0000, 1, 32'h900, 0, 0,    4'b0000, 3'b111, 1, 32'h800, 0, 1);
    add(4'b0000, 0, 0, 0, 0,          4'b0000, 3'b111, 0, 0, 0, 0);
    add(4'b0000, 0, 0, 0, 0,          4'b0000, 3'b000, 0, 0, 0, 0);

    // reset with busy inputs: everything low
    rst = 1'b0;
    drive(4'hF, 0, 0, 1, 32'h8);
    #2;
    chk_all("reset", 4'b0000, 3'b000, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(4'h0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk_all("post_reset", 4'b0000, 3'b000, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      drive(vecs[i].stall, vecs[i].exf, vecs[i].exa, vecs[i].intf, vecs[i].inta);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vecs[i].e_hold, vecs[i].e_flush, vecs[i].e_pcj,
              vecs[i].e_addr, vecs[i].e_ack, vecs[i].e_pend);
    end

    // mid-operation reset drops a buffered redirect
    @(posedge clk); #1;
    drive(4'b0001, 1, 32'hA00, 0, 0);
    @(posedge clk); #1;
    drive(4'b0001, 0, 0, 0, 0);
    @(negedge clk);
    chk("midrst.pend_before", 32'(redirect_pending), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk_all("midrst.asserted", 4'b0000, 3'b000, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk_all("midrst.held", 4'b0001, 3'b000, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(4'b0000, 0, 0, 0, 0);
    @(negedge clk);
    chk_all("midrst.release", 4'b0000, 3'b000, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_all("midrst.after", 4'b0000, 3'b000, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
